cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run sequencer for the single-cycle heart-rate CPU. It accepts one input sample per job and loads it into the memory-mapped input port (0xF9). It boots the CPU and instruction memory with a reset pulse, releases the core, and snoops the data-store bus for the three result bytes (0xFD, 0xFE, 0xFF). When the core fetches HALT, or a watchdog expires, it returns the results through a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum number of RUN cycles before the job is aborted; range 1..65535.
- `BOOT_CYCLES`, default 2: number of cycles `cpu_rst` is held high; minimum 1.

Ports (name, direction, width, meaning):
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `start_valid` in 1: a job request is present.
- `start_ready` out 1: high only in IDLE.
- `start_data` in 8: input sample for the job.
- `abort` in 1: synchronous cancel, honoured in BOOT, RUN and DONE.
- `cpu_rst` out 1: active-high synchronous reset to the CPU and instruction memory.
- `cpu_hold` out 1: freezes the CPU PC and suppresses its register and memory writes.
- `instr` in 16: instruction currently fetched by the CPU.
- `cpu_mem_we` in 1: CPU data-store strobe.
- `cpu_mem_addr` in 8: CPU data address.
- `cpu_mem_wdata` in 8: CPU store data.
- `in_port_data` out 8: value returned to the CPU on loads from 0xF9.
- `res_valid` out 1: result is available.
- `res_ready` in 1: consumer accepts the result.
- `res_q0`, `res_q1`, `res_q2` out 8 each: last bytes stored to 0xFD, 0xFE and 0xFF.
- `res_status` out 2: 00 = OK, 01 = TIMEOUT.
- `run_cycles` out 16: number of RUN cycles the job took.

## Operation
States:
- IDLE: `start_ready`=1. On `start_valid`, latch `start_data` into `in_port_data`, clear the capture registers and go to BOOT.
- BOOT: `cpu_rst`=1 and `cpu_hold`=1 for BOOT_CYCLES cycles, then go to RUN with the cycle counter at 0.
- RUN: `cpu_hold`=0 and the counter increments every cycle.
  - HALT is detected when `instr` == 16'h0001. The counter then includes the HALT cycle, status is set to OK and the state moves to DONE.
  - If the counter reaches TIMEOUT_CYCLES without a HALT, status is set to TIMEOUT and the state moves to DONE.
  - If HALT and timeout occur in the same cycle, HALT wins.
- DONE: `cpu_hold`=1 and `res_valid`=1. All result outputs stay stable until `res_valid` && `res_ready`; the state then returns to IDLE.

Store snoop:
- Active in RUN only.
- A store with `cpu_mem_we`=1 to 0xFD, 0xFE or 0xFF overwrites the matching `res_q*` register. The last write wins.
- A store in the final RUN cycle (the timeout cycle) is captured.
- Stores to any other address are ignored.

Abort:
- In BOOT, RUN or DONE, `abort` sends the state to IDLE on the next edge with no result (`res_valid` drops).
- `abort` in IDLE has no effect.
- `abort` takes priority over HALT, timeout and `res_ready`.

`in_port_data` holds the job's sample from acceptance until the next job is accepted.

## Timing
- Reset values: state IDLE, `start_ready`=1, `cpu_rst`=0, `cpu_hold`=1, `res_valid`=0, `res_q*`=0, `res_status`=00, `run_cycles`=0, `in_port_data`=0.
- Asserting `RESET_N` mid-job forces all reset values immediately, asynchronously; the job is lost.
- Start accepted at edge N: BOOT occupies cycles N+1 .. N+BOOT_CYCLES; the first RUN cycle is N+BOOT_CYCLES+1.
- HALT seen in RUN cycle k (counting from 1): `res_valid` rises on the next cycle, with `run_cycles`=k.
- Timeout: `res_valid` rises on the cycle after RUN cycle TIMEOUT_CYCLES, with `run_cycles`=TIMEOUT_CYCLES.
- `res_valid` with `res_ready` already high: one DONE cycle, then IDLE. A new start can be accepted the cycle after that.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `cpu_run_pkg` holds:
  - the state enum;
  - address constants IN_ADDR=8'hF9, OUT0_ADDR=8'hFD, OUT1_ADDR=8'hFE, OUT2_ADDR=8'hFF;
  - HALT_INSTR=16'h0001;
  - status codes ST_OK and ST_TIMEOUT.
- Sub-module `io_store_capture` holds the three address-decoded capture registers, with enable, clear and write ports.
- The FSM, counter and handshake logic live in `cpu_run_ctrl`.

## Test plan
1. Basic job: stub CPU, BOOT_CYCLES=2, `start_data`=0x10.
   - Required: `in_port_data`=0x10 and `cpu_rst` high for exactly 2 cycles.
   - Stub stores 0x04→0xFD, 0x03→0xFE, 0xFF→0xFF, then presents HALT in RUN cycle 5.
   - Required: `res_q0..q2`=04/03/FF, status OK, `run_cycles`=5.
2. Timeout: TIMEOUT_CYCLES=8, no HALT, a store of 0x55→0xFD in RUN cycle 8.
   - Required: status TIMEOUT, `run_cycles`=8, `res_q0`=0x55.
3. Simultaneous HALT and timeout: HALT in RUN cycle 8 with TIMEOUT_CYCLES=8.
   - Required: status OK.
4. Backpressure: `res_ready` held low for 10 cycles.
   - Required: `res_valid` and all result fields stable, `start_ready`=0, `cpu_hold`=1 throughout.
   - A second `start_valid` during this time is not accepted.
5. Abort and reset mid-job:
   - `abort` in RUN cycle 3: IDLE next cycle, `res_valid` never rises.
   - `RESET_N` low in RUN: `cpu_hold`=1 and `cpu_rst`=0 immediately.
   - A following job runs normally.
6. Snoop filter: stores to 0xF9, 0xFC and 0x00, plus a store to 0xFD while in DONE.
   - Required: `res_q*` unchanged; a store of 0xAA then 0xBB to 0xFE yields `res_q1`=0xBB.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared states, bus addresses and status codes for the run sequencer
package cpu_run_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BOOT, S_RUN, S_DONE} state_t;
  localparam logic [7:0] IN_ADDR = 8'hF9;
  localparam logic [7:0] OUT0_ADDR = 8'hFD;
  localparam logic [7:0] OUT1_ADDR = 8'hFE;
  localparam logic [7:0] OUT2_ADDR = 8'hFF;
  localparam logic [15:0] HALT_INSTR = 16'h0001;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
endpackage

// File: rtl/io_store_capture.sv
// io_store_capture: address-decoded capture of the three result bytes from the CPU store bus
module io_store_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] q0,
  output logic [7:0] q1,
  output logic [7:0] q2
);
  import cpu_run_pkg::*;
  // clear wins over capture; each result byte keeps the last store to its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (clr) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (en && we) begin
      if (addr == OUT0_ADDR) q0 <= wdata;
      if (addr == OUT1_ADDR) q1 <= wdata;
      if (addr == OUT2_ADDR) q2 <= wdata;
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: boots the CPU per job, watches for HALT or watchdog expiry and hands back results
module cpu_run_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int BOOT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  start_data,
  input  logic        abort,
  output logic        cpu_rst,
  output logic        cpu_hold,
  input  logic [15:0] instr,
  input  logic        cpu_mem_we,
  input  logic [7:0]  cpu_mem_addr,
  input  logic [7:0]  cpu_mem_wdata,
  output logic [7:0]  in_port_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_q0,
  output logic [7:0]  res_q1,
  output logic [7:0]  res_q2,
  output logic [1:0]  res_status,
  output logic [15:0] run_cycles
);
  import cpu_run_pkg::*;
  state_t state, state_d;
  logic [15:0] boot_cnt, boot_d, cnt_d;
  logic [1:0] status_d;
  logic [7:0] in_d;
  logic clr;
  assign start_ready = state == S_IDLE;
  assign cpu_rst = state == S_BOOT;
  assign cpu_hold = state != S_RUN;
  assign res_valid = state == S_DONE;
  // state, boot/run counters, status and the sampled input byte
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      boot_cnt <= '0;
      run_cycles <= '0;
      res_status <= ST_OK;
      in_port_data <= '0;
    end else begin
      state <= state_d;
      boot_cnt <= boot_d;
      run_cycles <= cnt_d;
      res_status <= status_d;
      in_port_data <= in_d;
    end
  end
  // sequencing: abort beats everything, HALT beats the watchdog in the same cycle
  always_comb begin
    state_d = state;
    boot_d = boot_cnt;
    cnt_d = run_cycles;
    status_d = res_status;
    in_d = in_port_data;
    clr = 1'b0;
    case (state)
      S_IDLE: if (start_valid) begin
        state_d = S_BOOT;
        boot_d = '0;
        cnt_d = '0;
        status_d = ST_OK;
        in_d = start_data;
        clr = 1'b1;
      end
      S_BOOT: begin
        if (abort) state_d = S_IDLE;
        else if (boot_cnt == 16'(BOOT_CYCLES - 1)) state_d = S_RUN;
        else boot_d = boot_cnt + 16'd1;
      end
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else begin
          cnt_d = run_cycles + 16'd1;
          if (instr == HALT_INSTR) begin
            state_d = S_DONE;
            status_d = ST_OK;
          end else if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            state_d = S_DONE;
            status_d = ST_TIMEOUT;
          end
        end
      end
      default: if (abort || res_ready) state_d = S_IDLE;
    endcase
  end
  io_store_capture u_cap (
    .clk(CLK),
    .rst_n(RESET_N),
    .en(state == S_RUN),
    .clr(clr),
    .we(cpu_mem_we),
    .addr(cpu_mem_addr),
    .wdata(cpu_mem_wdata),
    .q0(res_q0),
    .q1(res_q1),
    .q2(res_q2)
  );
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: stub-CPU directed jobs with a result scoreboard checked at each handshake
module tb_cpu_run_ctrl;
  typedef struct packed {
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [1:0] st;
    logic [15:0] cyc;
  } exp_t;
  logic CLK, RESET_N, start_valid, start_ready, abort, cpu_rst, cpu_hold;
  logic cpu_mem_we, res_valid, res_ready;
  logic [7:0] start_data, cpu_mem_addr, cpu_mem_wdata, in_port_data, res_q0, res_q1, res_q2;
  logic [15:0] instr, run_cycles;
  logic [1:0] res_status;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic p_we[16], p_halt[16], p_abort[16];
  logic [7:0] p_addr[16], p_data[16];

  cpu_run_ctrl #(.TIMEOUT_CYCLES(8), .BOOT_CYCLES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
    .abort(abort), .cpu_rst(cpu_rst), .cpu_hold(cpu_hold), .instr(instr),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .in_port_data(in_port_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_q0(res_q0), .res_q1(res_q1), .res_q2(res_q2),
    .res_status(res_status), .run_cycles(run_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted result must match the oldest expected job
  always @(negedge CLK) begin
    if (RESET_N && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(res_valid), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_q0", 64'(res_q0), 64'(e.q0));
        chk("res_q1", 64'(res_q1), 64'(e.q1));
        chk("res_q2", 64'(res_q2), 64'(e.q2));
        chk("res_status", 64'(res_status), 64'(e.st));
        chk("run_cycles", 64'(run_cycles), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      p_we[i] = 0; p_halt[i] = 0; p_abort[i] = 0; p_addr[i] = 0; p_data[i] = 0;
    end
  endtask

  task automatic st(input int c, input logic [7:0] a, input logic [7:0] d);
    p_we[c] = 1; p_addr[c] = a; p_data[c] = d;
  endtask

  task automatic run_job(input logic [7:0] sample, input int ncyc);
    int rc, g;
    start_data = sample;
    start_valid = 1;
    tick();
    start_valid = 0;
    rc = 0;
    g = 0;
    while (cpu_hold && g < 16) begin
      if (cpu_rst) rc++;
      tick();
      g++;
    end
    chk("boot_rst_cycles", 64'(rc), 64'd2);
    chk("in_port_data", 64'(in_port_data), 64'(sample));
    for (int c = 0; c < ncyc; c++) begin
      instr = p_halt[c] ? 16'h0001 : 16'h1234;
      cpu_mem_we = p_we[c];
      cpu_mem_addr = p_addr[c];
      cpu_mem_wdata = p_data[c];
      abort = p_abort[c];
      tick();
    end
    instr = 16'h1234;
    cpu_mem_we = 0;
    cpu_mem_addr = 0;
    cpu_mem_wdata = 0;
    abort = 0;
  endtask

  initial begin
    logic any_valid;
    RESET_N = 0; start_valid = 0; start_data = 0; abort = 0; instr = 16'h1234;
    cpu_mem_we = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0; res_ready = 1;
    #12;
    chk("reset_outputs",
        64'({start_ready, cpu_rst, cpu_hold, res_valid, res_q0, res_q1, res_q2, res_status, run_cycles, in_port_data}),
        64'({1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 2'b00, 16'h0, 8'h0}));
    RESET_N = 1;
    tick();
    // basic job: halt in RUN cycle 5
    clear_prog();
    st(0, 8'hFD, 8'h04); st(1, 8'hFE, 8'h03); st(2, 8'hFF, 8'hFF); p_halt[4] = 1;
    sb.push_back('{8'h04, 8'h03, 8'hFF, 2'b00, 16'd5});
    run_job(8'h10, 5);
    chk("basic_valid_rise", 64'(res_valid), 64'd1);
    tick();
    // watchdog expiry with a store in the final RUN cycle
    clear_prog();
    st(7, 8'hFD, 8'h55);
    sb.push_back('{8'h55, 8'h00, 8'h00, 2'b01, 16'd8});
    run_job(8'h20, 8);
    chk("timeout_valid_rise", 64'(res_valid), 64'd1);
    tick();
    // HALT on the watchdog cycle
    clear_prog();
    p_halt[7] = 1;
    sb.push_back('{8'h00, 8'h00, 8'h00, 2'b00, 16'd8});
    run_job(8'h30, 8);
    tick();
    // backpressure: results frozen, starts refused, DONE-state stores ignored
    res_ready = 0;
    clear_prog();
    st(0, 8'hFD, 8'h12); st(1, 8'hFE, 8'h34); st(2, 8'hFF, 8'h56); p_halt[3] = 1;
    sb.push_back('{8'h12, 8'h34, 8'h56, 2'b00, 16'd4});
    run_job(8'h40, 4);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1; start_data = 8'h99; instr = 16'h0001;
      cpu_mem_we = 1; cpu_mem_addr = 8'hFD; cpu_mem_wdata = 8'hEE;
      #3;
      chk("backpressure_hold",
          64'({res_valid, start_ready, cpu_hold, res_q0, res_q1, res_q2, res_status, run_cycles, in_port_data}),
          64'({1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 2'b00, 16'd4, 8'h40}));
      tick();
    end
    start_valid = 0; instr = 16'h1234; cpu_mem_we = 0;
    res_ready = 1;
    tick();
    chk("backpressure_release", 64'({start_ready, in_port_data}), 64'({1'b1, 8'h40}));
    // snoop filter and last-write-wins
    clear_prog();
    st(0, 8'hF9, 8'h11); st(1, 8'hFC, 8'h22); st(2, 8'h00, 8'h33);
    st(3, 8'hFE, 8'hAA); st(4, 8'hFE, 8'hBB); p_halt[5] = 1;
    sb.push_back('{8'h00, 8'hBB, 8'h00, 2'b00, 16'd6});
    run_job(8'h50, 6);
    tick();
    // abort in RUN cycle 3
    clear_prog();
    st(0, 8'hFD, 8'h66); p_abort[2] = 1;
    run_job(8'h60, 3);
    chk("abort_to_idle", 64'({start_ready, res_valid, cpu_hold}), 64'({1'b1, 1'b0, 1'b1}));
    any_valid = 0;
    for (int i = 0; i < 10; i++) begin
      instr = 16'h0001;
      any_valid |= res_valid;
      tick();
    end
    instr = 16'h1234;
    chk("abort_no_result", 64'(any_valid), 64'd0);
    // asynchronous reset during RUN
    clear_prog();
    st(0, 8'hFD, 8'h77);
    run_job(8'h70, 1);
    chk("in_run_before_reset", 64'({cpu_hold, res_q0}), 64'({1'b0, 8'h77}));
    RESET_N = 0;
    #1;
    chk("async_reset",
        64'({cpu_hold, cpu_rst, start_ready, res_valid, res_q0, run_cycles, in_port_data}),
        64'({1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 8'h00}));
    #2;
    RESET_N = 1;
    tick();
    // following job runs normally
    clear_prog();
    st(0, 8'hFE, 8'h21); p_halt[1] = 1;
    sb.push_back('{8'h00, 8'h21, 8'h00, 2'b00, 16'd2});
    run_job(8'h80, 2);
    chk("after_reset_valid", 64'(res_valid), 64'd1);
    tick();
    tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
